parallel_master: RTL and testbench

- Bus-cycle generator on the CPLD's 10-bit-address / 8-bit-data parallel bus.
- Sits directly upstream of the parallel slave register file: turns a single-cycle request from internal logic into a correctly timed write or read cycle on ADR/Data/BWR/BRD.
- The slave latches Data on the rising edge of BWR and drives Data while BRD is low, so this block guarantees setup/hold around both strobes and never contends on Data.

---
 rtl/parallel_master.sv | 179 +++++++++++++++++
 tb/tb_parallel_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/parallel_master.sv
// parallel_master: turns a one-cycle request into a timed read or write cycle on ADR/Data/BWR/BRD.
// Build option PAR_READBACK_EN: every write is followed by a readback of the same address and a masked compare.
module parallel_master #(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned STROBE_CYC  = 4,
   parameter int unsigned HOLD_CYC    = 1,
   parameter logic [7:0]  VERIFY_MASK = 8'hFF
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       req,
   input  logic       we,
   input  logic [9:0] addr,
   input  logic [7:0] wdata,
   output logic       ready,
   output logic       done,
   output logic [7:0] rdata,
   output logic       mismatch,
   output logic [9:0] ADR,
   inout  logic [7:0] Data,
   output logic       BWR,
   output logic       BRD
);

   localparam int unsigned MAX_SU = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int unsigned MAX_CYC = (MAX_SU > HOLD_CYC) ? MAX_SU : HOLD_CYC;
   localparam int unsigned CW = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

`ifdef PAR_READBACK_EN
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RB_SETUP, RB_STROBE, RB_HOLD} state_e;
`else
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
`endif

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [9:0]      adr_q, adr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            bwr_q, bwr_d;
   logic            brd_q, brd_d;
   logic            oe_q, oe_d;
   logic            last;
`ifdef PAR_READBACK_EN
   logic            mismatch_q, mismatch_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      last    = 1'b0;
`ifdef PAR_READBACK_EN
      mismatch_d = mismatch_q;
`endif
      case (state_q)
         IDLE: ;
         SETUP:
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LD;
            end
         STROBE:
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
               // Capture while BRD is still low; the slave releases Data as BRD rises.
               if (!we_q) begin
                  rdata_d = Data;
`ifdef PAR_READBACK_EN
                  mismatch_d = 1'b0;
`endif
               end
            end
         HOLD:
            if (cnt_q == '0) begin
`ifdef PAR_READBACK_EN
               if (we_q) begin
                  state_d = RB_SETUP;
                  cnt_d   = SETUP_LD;
               end else
`endif
               begin
                  state_d = IDLE;
                  last    = 1'b1;
               end
            end
`ifdef PAR_READBACK_EN
         RB_SETUP:
            if (cnt_q == '0) begin
               state_d = RB_STROBE;
               cnt_d   = STROBE_LD;
            end
         RB_STROBE:
            if (cnt_q == '0) begin
               state_d    = RB_HOLD;
               cnt_d      = HOLD_LD;
               rdata_d    = Data;
               mismatch_d = |((Data ^ wdata_q) & VERIFY_MASK);
            end
         RB_HOLD:
            if (cnt_q == '0) begin
               state_d = IDLE;
               last    = 1'b1;
            end
`endif
         default: state_d = IDLE;
      endcase

      ready = (state_q == IDLE) || last;
      done  = last;

      // Accepting in the final hold cycle chains transactions with no idle clock.
      if (req && ready) begin
         state_d = SETUP;
         cnt_d   = SETUP_LD;
         we_d    = we;
         adr_d   = addr;
         wdata_d = wdata;
      end

      bwr_d = !(state_d == STROBE && we_d);
      brd_d = !(state_d == STROBE && !we_d);
`ifdef PAR_READBACK_EN
      if (state_d == RB_STROBE) brd_d = 1'b0;
`endif
      oe_d  = we_d && (state_d == SETUP || state_d == STROBE || state_d == HOLD);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         bwr_q   <= 1'b1;
         brd_q   <= 1'b1;
         oe_q    <= 1'b0;
`ifdef PAR_READBACK_EN
         mismatch_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         bwr_q   <= bwr_d;
         brd_q   <= brd_d;
         oe_q    <= oe_d;
`ifdef PAR_READBACK_EN
         mismatch_q <= mismatch_d;
`endif
      end
   end

   assign ADR   = adr_q;
   assign BWR   = bwr_q;
   assign BRD   = brd_q;
   assign rdata = rdata_q;
   assign Data  = oe_q ? wdata_q : 'z;
`ifdef PAR_READBACK_EN
   assign mismatch = mismatch_q;
`else
   // Without readback there is nothing to compare; the mask is inert.
   assign mismatch = 1'b0 & (|VERIFY_MASK);
`endif

endmodule

// File: tb/tb_parallel_master.sv
// Bench for parallel_master: directed plus random transactions against a slave model and a cycle-level reference.
module tb_parallel_master;

   localparam int unsigned S = 2;
   localparam int unsigned T = 4;
   localparam int unsigned H = 1;
   localparam logic [7:0]  MASK = 8'h1F;
   localparam logic [7:0]  BUS_IDLE = 8'hFF;
`ifdef PAR_READBACK_EN
   localparam bit RB_BUILD = 1'b1;
`else
   localparam bit RB_BUILD = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       req, we;
   logic [9:0] addr;
   logic [7:0] wdata;
   logic       ready, done, mismatch, BWR, BRD;
   logic [7:0] rdata;
   logic [9:0] ADR;
   wire  [7:0] data_bus;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [7:0] slv_mem [1024];
   logic [7:0] slv_keep;
   logic       slv_stuck;

   logic [7:0] ref_mem [1024];
   bit         written [1024];
   logic [7:0] exp_rdata;
   logic       exp_mis;
   logic [9:0] last_adr;

   always #5 CLK = ~CLK;

   parallel_master #(
      .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .VERIFY_MASK(MASK)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ready(ready), .done(done), .rdata(rdata), .mismatch(mismatch),
      .ADR(ADR), .Data(data_bus), .BWR(BWR), .BRD(BRD)
   );

   // Pull-ups make an undriven bus read as FF, so any stray master drive is visible.
   for (genvar gi = 0; gi < 8; gi++) begin : g_pull
      pullup pu (data_bus[gi]);
   end

   // Slave: latches on BWR rise (only implemented bits), drives while BRD is low.
   assign data_bus = (BRD == 1'b0) ? (slv_stuck ? 8'h00 : slv_mem[ADR]) : 8'hzz;
   always @(posedge BWR) if (RST_N) slv_mem[ADR] <= data_bus & slv_keep;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic idle(input int unsigned n);
      req = 1'b0;
      for (int unsigned c = 0; c < n; c++) begin
         @(negedge CLK);
         chk("idle_ready", 32'(ready), 32'(1'b1));
         chk("idle_done", 32'(done), 32'(1'b0));
         chk("idle_bwr", 32'(BWR), 32'(1'b1));
         chk("idle_brd", 32'(BRD), 32'(1'b1));
         chk("idle_data", 32'(data_bus), 32'(BUS_IDLE));
         chk("idle_adr", 32'(ADR), 32'(last_adr));
         chk("idle_rdata", 32'(rdata), 32'(exp_rdata));
         chk("idle_mismatch", 32'(mismatch), 32'(exp_mis));
      end
   endtask

   // Called at a negedge where the DUT is ready; returns at the negedge of the done cycle.
   task automatic run_txn(input bit w, input logic [9:0] a, input logic [7:0] d,
                          input int unsigned abort_at);
      int unsigned l1, len, j;
      bit          rb, ph2, win, e_bwr, e_brd, e_last;
      logic [7:0]  rd_val, new_rd, e_data;
      logic        new_mis;
      l1  = S + T + H;
      rb  = RB_BUILD && w;
      len = rb ? 2 * l1 : l1;
      chk("ready_at_req", 32'(ready), 32'(1'b1));
      req = 1'b1; we = w; addr = a; wdata = d;
      if (w && abort_at == 0) begin
         ref_mem[a] = d & slv_keep;
         written[a] = 1'b1;
      end
      rd_val  = slv_stuck ? 8'h00 : ref_mem[a];
      new_rd  = (!w || rb) ? rd_val : exp_rdata;
      new_mis = rb ? |((rd_val ^ d) & MASK) : (w ? exp_mis : 1'b0);
      @(negedge CLK);
      for (int unsigned k = 1; k <= len; k++) begin
         ph2    = k > l1;
         j      = ph2 ? k - l1 : k;
         win    = (j > S) && (j <= S + T);
         e_bwr  = !(w && !ph2 && win);
         e_brd  = !(win && (!w || ph2));
         e_data = (w && !ph2) ? d : (!e_brd ? rd_val : BUS_IDLE);
         e_last = (k == len);
         chk("adr", 32'(ADR), 32'(a));
         chk("bwr", 32'(BWR), 32'(e_bwr));
         chk("brd", 32'(BRD), 32'(e_brd));
         chk("data", 32'(data_bus), 32'(e_data));
         chk("done", 32'(done), 32'(e_last));
         chk("ready", 32'(ready), 32'(e_last));
         chk("rdata", 32'(rdata), 32'(e_last ? new_rd : exp_rdata));
         chk("mismatch", 32'(mismatch), 32'(e_last ? new_mis : exp_mis));
         if (k == abort_at) begin
            RST_N = 1'b0;
            return;
         end
         if (k < len) begin
            req = 1'($urandom); we = 1'($urandom);
            addr = 10'($urandom); wdata = 8'($urandom);
            @(negedge CLK);
         end
      end
      exp_rdata = new_rd;
      exp_mis   = new_mis;
      last_adr  = a;
   endtask

   initial begin
      #500000;
      $fatal(1, "FAIL watchdog: simulation time limit reached");
   end

   initial begin
      logic [9:0] a;
      logic [7:0] d;
      bit         w;
      RST_N = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      slv_keep = 8'hFF; slv_stuck = 1'b0;
      exp_rdata = '0; exp_mis = 1'b0; last_adr = '0;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_bwr", 32'(BWR), 32'(1'b1));
      chk("rst_brd", 32'(BRD), 32'(1'b1));
      chk("rst_data", 32'(data_bus), 32'(BUS_IDLE));
      chk("rst_adr", 32'(ADR), 32'(10'h000));
      chk("rst_ready", 32'(ready), 32'(1'b1));
      chk("rst_done", 32'(done), 32'(1'b0));
      chk("rst_rdata", 32'(rdata), 32'(8'h00));
      chk("rst_mismatch", 32'(mismatch), 32'(1'b0));
      RST_N = 1'b1;
      idle(2);

      run_txn(1'b1, 10'h050, 8'h15, 0);
      idle(1);
      run_txn(1'b0, 10'h050, 8'h00, 0);
      idle(1);

      run_txn(1'b1, 10'h051, 8'h2C, 0);
      run_txn(1'b1, 10'h052, 8'h73, 0);
      run_txn(1'b0, 10'h051, 8'h00, 0);
      run_txn(1'b0, 10'h052, 8'h00, 0);
      idle(2);

      for (int unsigned i = 0; i < 40; i++) begin
         a = 10'h100 + 10'($urandom_range(0, 15));
         w = ($urandom_range(0, 1) == 1) || !written[a];
         d = 8'($urandom_range(0, 254));
         run_txn(w, a, d, 0);
         if ($urandom_range(0, 2) == 0) idle(1 + $urandom_range(0, 2));
      end
      idle(1);

      run_txn(1'b1, 10'h3FF, 8'h6B, S + 2);
      req = 1'b0;
      @(negedge CLK);
      chk("abort_bwr", 32'(BWR), 32'(1'b1));
      chk("abort_brd", 32'(BRD), 32'(1'b1));
      chk("abort_data", 32'(data_bus), 32'(BUS_IDLE));
      chk("abort_ready", 32'(ready), 32'(1'b1));
      chk("abort_done", 32'(done), 32'(1'b0));
      chk("abort_adr", 32'(ADR), 32'(10'h000));
      chk("abort_rdata", 32'(rdata), 32'(8'h00));
      RST_N = 1'b1;
      exp_rdata = '0; exp_mis = 1'b0; last_adr = '0;
      idle(1);
      run_txn(1'b0, 10'h050, 8'h00, 0);
      idle(1);

      slv_keep = MASK;
      run_txn(1'b1, 10'h050, 8'hF5, 0);
      idle(1);
      run_txn(1'b0, 10'h050, 8'h00, 0);
      idle(1);
      slv_stuck = 1'b1;
      run_txn(1'b1, 10'h060, 8'h3A, 0);
      idle(1);
      slv_stuck = 1'b0;
      run_txn(1'b0, 10'h060, 8'h00, 0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
